// File: rtl/blue_seq_ctrl.sv
// Blue instruction sequencer: fetches 16-bit words over req/ack, drives the
// result-select decoder through sel, and writes outA/outB back into RA/RB.
module blue_seq_ctrl #(
  parameter int PC_W = 8,
  parameter int DW   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            load_en,
  input  logic [DW-1:0]   load_a,
  input  logic [DW-1:0]   load_b,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [DW-1:0]   imem_data,
  output logic [2:0]      sel,
  output logic [DW-1:0]   RA,
  output logic [DW-1:0]   RB,
  input  logic [DW-1:0]   outA,
  input  logic [DW-1:0]   outB,
  output logic            busy,
  output logic            done,
  output logic [15:0]     instr_cnt
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  logic [2:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [2:0]      r_ir_op;
  logic            r_ir_hlt;
  logic [2:0]      r_sel;
  logic [DW-1:0]   r_ra;
  logic [DW-1:0]   r_rb;
  logic [15:0]     r_cnt;
  logic            w_idle_like;
  logic            w_unused_ir;

  // Retired-instruction counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Only opcode and HLT are architecturally meaningful; low bits are don't-care.
  assign w_unused_ir = ^imem_data[11:0];
  assign w_idle_like = (r_state == S_IDLE) || (r_state == S_HALT);

  // Sequencer state, program counter, instruction and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_ir_op  <= 3'b000;
      r_ir_hlt <= 1'b0;
      r_sel    <= 3'b000;
      r_ra     <= '0;
      r_rb     <= '0;
      r_cnt    <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          // load and start may coincide; the first instruction sees the load
          if (load_en) begin
            r_ra <= load_a;
            r_rb <= load_b;
          end
          if (start) begin
            r_pc    <= '0;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            r_ir_op  <= imem_data[15:13];
            r_ir_hlt <= imem_data[12];
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (r_ir_hlt) begin
            r_state <= S_HALT;
          end else begin
            r_sel   <= r_ir_op;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // settle cycle: sel is stable so the ALUs and decoder resolve
          r_state <= S_WB;
        end
        S_WB: begin
          r_ra    <= outA;
          r_rb    <= outB;
          r_pc    <= r_pc + PC_W'(1);
          r_cnt   <= sat_inc(r_cnt);
          r_state <= S_FETCH;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = (r_state == S_FETCH);
  assign imem_addr = r_pc;
  assign sel       = r_sel;
  assign RA        = r_ra;
  assign RB        = r_rb;
  assign busy      = !w_idle_like && (r_state != 3'd6) && (r_state != 3'd7);
  assign done      = (r_state == S_HALT);
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_blue_seq_ctrl.sv
// Directed bench for blue_seq_ctrl: instruction memory with programmable ack
// delay, a small reference decoder/ALU, and a PC_W=2 instance for PC wrap.
module tb_blue_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start, load_en;
  logic [15:0] load_a, load_b;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [2:0]  sel;
  logic [15:0] RA, RB, outA, outB;
  logic        busy, done;
  logic [15:0] instr_cnt;

  logic        start2;
  logic        imem_req2, imem_ack2;
  logic [1:0]  imem_addr2;
  logic [15:0] imem_data2;
  logic [2:0]  sel2;
  logic [15:0] RA2, RB2, outA2, outB2;
  logic        busy2, done2;
  logic [15:0] instr_cnt2;

  logic [15:0] mem [0:255];
  int          ack_dly;
  int          wcnt;
  logic        stray_ack;
  int          nlog;
  logic [1:0]  alog [0:15];

  int checks;
  int failures;

  blue_seq_ctrl #(.PC_W(8), .DW(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en),
    .load_a(load_a), .load_b(load_b),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .sel(sel), .RA(RA), .RB(RB),
    .outA(outA), .outB(outB), .busy(busy), .done(done), .instr_cnt(instr_cnt)
  );

  blue_seq_ctrl #(.PC_W(2), .DW(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .load_en(1'b0),
    .load_a(16'h0000), .load_b(16'h0000),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2),
    .imem_data(imem_data2), .sel(sel2), .RA(RA2), .RB(RB2),
    .outA(outA2), .outB(outB2), .busy(busy2), .done(done2), .instr_cnt(instr_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory for the main instance: ack after ack_dly waiting cycles, plus stray acks
  assign imem_data = mem[imem_addr];
  assign imem_ack  = (imem_req && (wcnt == ack_dly)) || stray_ack;
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  // reference decoder/ALU
  always_comb begin
    outA = RA;
    outB = RB;
    case (sel)
      3'b100: outA = RA + RB;
      3'b101: outA = RA - RB;
      3'b110: outA = RA | RB;
      3'b111: outA = RA & RB;
      3'b000: outA = RA ^ RB;
      3'b001: outA = RA >> 1;
      3'b010: outA = RB;
      3'b011: begin outA = RB; outB = RA; end
      default: outA = RA;
    endcase
  end

  // wrap instance: immediate ack, ADD words, HLT on the fifth fetch
  assign imem_ack2  = imem_req2;
  assign imem_data2 = (nlog == 4) ? 16'h1000 : 16'h8000;
  assign outA2      = RA2 + RB2;
  assign outB2      = RB2;
  always @(posedge clk) begin
    if (imem_req2 && imem_ack2 && nlog < 16) begin
      alog[nlog] <= imem_addr2;
      nlog       <= nlog + 1;
    end
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; load_en = 1'b0; load_a = '0; load_b = '0;
    start2 = 1'b0; ack_dly = 0; stray_ack = 1'b0; nlog = 0; wcnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000;
    tick(2);

    // reset state
    chk_val("rst_busy", busy, 0);
    chk_val("rst_done", done, 0);
    chk_val("rst_req", imem_req, 0);
    chk_val("rst_ra", RA, 0);
    chk_val("rst_rb", RB, 0);
    chk_val("rst_sel", sel, 0);
    chk_val("rst_cnt", instr_cnt, 0);
    chk_val("rst_addr", imem_addr, 0);
    rst = 1'b0;
    tick(1);

    // ADD then HLT, load coincident with start
    mem[0] = 16'h8000; mem[1] = 16'h1000;
    load_en = 1'b1; load_a = 16'h0003; load_b = 16'h0005; start = 1'b1;
    tick(1);
    load_en = 1'b0; start = 1'b0;
    chk_val("add_fetch_req", imem_req, 1);
    chk_val("add_fetch_busy", busy, 1);
    chk_val("add_load_ra", RA, 16'h0003);
    tick(2);
    chk_val("add_exec_sel", sel, 3'b100);
    tick(2);
    chk_val("add_wb_ra", RA, 16'h0008);
    chk_val("add_wb_rb", RB, 16'h0005);
    chk_val("add_wb_pc", imem_addr, 1);
    chk_val("add_wb_cnt", instr_cnt, 1);
    tick(2);
    chk_val("add_halt_done", done, 1);
    chk_val("add_halt_busy", busy, 0);
    chk_val("add_halt_pc", imem_addr, 1);
    chk_val("add_halt_cnt", instr_cnt, 1);

    // EXCH from HALT with load
    mem[0] = 16'h6000; mem[1] = 16'h1000;
    load_en = 1'b1; load_a = 16'h1234; load_b = 16'hABCD; start = 1'b1;
    tick(1);
    load_en = 1'b0; start = 1'b0;
    chk_val("exch_done_drop", done, 0);
    chk_val("exch_decode_sel_old", sel, 3'b100);
    tick(2);
    chk_val("exch_exec_sel", sel, 3'b011);
    tick(2);
    chk_val("exch_ra", RA, 16'hABCD);
    chk_val("exch_rb", RB, 16'h1234);
    tick(2);
    chk_val("exch_halt", done, 1);
    chk_val("exch_cnt", instr_cnt, 2);

    // ack delayed 3 cycles, stray acks outside FETCH
    mem[0] = 16'h8000; mem[1] = 16'h1000; ack_dly = 3;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_val("dly_req", imem_req, 1);
      chk_val("dly_addr", imem_addr, 0);
      tick(1);
    end
    chk_val("dly_req_last", imem_req, 1);
    tick(1);
    chk_val("dly_decode_busy", busy, 1);
    chk_val("dly_decode_req", imem_req, 0);
    stray_ack = 1'b1;
    tick(2);
    stray_ack = 1'b0;
    chk_val("dly_pre_wb_ra", RA, 16'hABCD);
    tick(1);
    chk_val("dly_wb_ra", RA, 16'hBE01);
    chk_val("dly_wb_rb", RB, 16'h1234);
    chk_val("dly_wb_cnt", instr_cnt, 3);
    chk_val("dly_wb_pc", imem_addr, 1);
    tick(5);
    chk_val("dly_halt", done, 1);
    stray_ack = 1'b1;
    tick(2);
    stray_ack = 1'b0;
    chk_val("halt_stray_done", done, 1);
    chk_val("halt_stray_busy", busy, 0);
    ack_dly = 0;

    // start/load_en pulsed during EXEC are ignored
    mem[0] = 16'h2000; mem[1] = 16'h8000; mem[2] = 16'h1000;
    load_en = 1'b1; load_a = 16'h0010; load_b = 16'h0001; start = 1'b1;
    tick(1);
    load_en = 1'b0; start = 1'b0;
    tick(2);
    chk_val("ign_exec_sel", sel, 3'b001);
    load_en = 1'b1; load_a = 16'hFFFF; load_b = 16'hFFFF; start = 1'b1;
    tick(1);
    load_en = 1'b0; start = 1'b0;
    chk_val("ign_ra_hold", RA, 16'h0010);
    chk_val("ign_rb_hold", RB, 16'h0001);
    tick(1);
    chk_val("ign_shr_ra", RA, 16'h0008);
    chk_val("ign_shr_rb", RB, 16'h0001);
    chk_val("ign_pc1", imem_addr, 1);
    tick(4);
    chk_val("ign_add_ra", RA, 16'h0009);
    chk_val("ign_pc2", imem_addr, 2);
    chk_val("ign_cnt", instr_cnt, 5);
    tick(2);
    chk_val("ign_halt", done, 1);

    // reset mid-fetch with a coincident ack
    ack_dly = 5;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    chk_val("mid_req", imem_req, 1);
    rst = 1'b1; stray_ack = 1'b1;
    tick(1);
    rst = 1'b0; stray_ack = 1'b0;
    chk_val("mid_req_drop", imem_req, 0);
    chk_val("mid_busy", busy, 0);
    chk_val("mid_done", done, 0);
    chk_val("mid_ra", RA, 0);
    chk_val("mid_rb", RB, 0);
    chk_val("mid_cnt", instr_cnt, 0);
    chk_val("mid_sel", sel, 0);
    tick(2);
    chk_val("mid_idle_stays", busy, 0);
    ack_dly = 0;
    mem[0] = 16'h4000; mem[1] = 16'h1000;
    load_en = 1'b1; load_a = 16'h0007; load_b = 16'h0009;
    tick(1);
    load_en = 1'b0; start = 1'b1;
    tick(1);
    start = 1'b0;
    chk_val("post_rst_addr", imem_addr, 0);
    chk_val("post_rst_req", imem_req, 1);
    tick(4);
    chk_val("post_rst_mov_ra", RA, 16'h0009);
    chk_val("post_rst_cnt", instr_cnt, 1);
    tick(2);
    chk_val("post_rst_halt", done, 1);

    // PC wrap on the PC_W=2 instance
    start2 = 1'b1;
    tick(1);
    start2 = 1'b0;
    tick(18);
    chk_val("wrap_nfetch", nlog, 5);
    for (int i = 0; i < 5; i++) chk_val("wrap_addr", alog[i], i % 4);
    chk_val("wrap_done", done2, 1);
    chk_val("wrap_cnt", instr_cnt2, 4);
    chk_val("wrap_pc", imem_addr2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
